fetch_controller: RTL and testbench

//   Instruction fetch sequencer between the word-wide memory and the variable-length x86 decoder.

---
 rtl/fetch_controller.sv | 167 ++++++++++++++++
 tb/tb_fetch_controller.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: issues aligned word reads, queues the returned bytes and
// presents a 4-byte window at the current PC to a variable-length decoder.
module fetch_controller #(
   parameter int unsigned              ADDRESS_WIDTH = 32,
   parameter int unsigned              DATA_WIDTH    = 32,
   parameter int unsigned              QUEUE_BYTES   = 16,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_enable,
   input  logic                     i_redirect,
   input  logic [ADDRESS_WIDTH-1:0] i_redirect_pc,
   output logic [ADDRESS_WIDTH-1:0] o_mem_address,
   output logic                     o_mem_cmd,
   output logic                     o_mem_valid,
   input  logic                     i_mem_ready,
   input  logic [DATA_WIDTH-1:0]    i_mem_data,
   input  logic                     i_mem_res_valid,
   output logic                     o_mem_res_ready,
   output logic [31:0]              o_window,
   output logic [2:0]               o_window_count,
   output logic                     o_window_valid,
   output logic [ADDRESS_WIDTH-1:0] o_window_pc,
   input  logic                     i_consume,
   input  logic [2:0]               i_consume_bytes,
   output logic [4:0]               o_occupancy
);

   localparam int unsigned PTR_W        = $clog2(QUEUE_BYTES);
   localparam logic        MEM_CMD_READ = 1'b0;
   localparam logic [4:0]  SPACE_LIMIT  = 5'(QUEUE_BYTES - 4);

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_DROP
   } state_t;

   state_t                     state, state_next;
   logic [ADDRESS_WIDTH-1:0]   mem_address, mem_address_next;
   logic [1:0]                 skip, skip_next;
   logic [PTR_W-1:0]           rd_ptr, rd_ptr_next;
   logic [PTR_W-1:0]           wr_ptr, wr_ptr_next;
   logic [4:0]                 occupancy, occupancy_next;
   logic [ADDRESS_WIDTH-1:0]   window_pc, window_pc_next;
   logic [7:0]                 queue [QUEUE_BYTES];

   logic                       handshake;
   logic                       push;
   logic [2:0]                 push_bytes;
   logic                       consume_ok;
   logic [2:0]                 consume_n;
   logic [3:0]                 push_en;
   logic [PTR_W-1:0]           push_idx [4];

   assign o_mem_cmd       = MEM_CMD_READ;
   assign o_mem_res_ready = 1'b1;
   assign o_mem_address   = mem_address;
   assign o_window_pc     = window_pc;
   assign o_occupancy     = occupancy;

   // Gated by reset so no request is visible while the block is held in reset.
   assign o_mem_valid = !reset && (state == S_REQ) && i_enable && (occupancy <= SPACE_LIMIT);
   assign handshake   = o_mem_valid && i_mem_ready;

   assign push       = (state == S_WAIT) && i_mem_res_valid && !i_redirect;
   assign push_bytes = 3'd4 - {1'b0, skip};
   assign consume_ok = i_consume && (i_consume_bytes != 3'd0) && (i_consume_bytes <= 3'd4);
   assign consume_n  = !consume_ok                        ? 3'd0 :
                       (i_consume_bytes < o_window_count) ? i_consume_bytes : o_window_count;

   assign o_window_count = (occupancy >= 5'd4) ? 3'd4 : occupancy[2:0];
   assign o_window_valid = (o_window_count == 3'd4);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      o_window = '0;
      for (int k = 0; k < 4; k++) begin
         o_window[8*k +: 8] = (occupancy > 5'(k)) ? queue[rd_ptr + PTR_W'(k)] : 8'h00;
      end
   end

   // Returned bytes below the skip offset belong before the PC and are never queued.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         push_en[k]  = push && (2'(k) >= skip);
         push_idx[k] = wr_ptr + PTR_W'(2'(k) - skip);
      end
   end

   always_comb begin
      state_next       = state;
      mem_address_next = mem_address;
      skip_next        = skip;
      rd_ptr_next      = rd_ptr;
      wr_ptr_next      = wr_ptr;
      occupancy_next   = occupancy;
      window_pc_next   = window_pc;

      if (i_redirect) begin
         rd_ptr_next      = '0;
         wr_ptr_next      = '0;
         occupancy_next   = '0;
         window_pc_next   = i_redirect_pc;
         mem_address_next = {i_redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
         skip_next        = i_redirect_pc[1:0];
         // A read already accepted for the old PC must be absorbed before issuing again.
         unique case (state)
            S_REQ:   state_next = handshake       ? S_DROP : S_REQ;
            S_WAIT:  state_next = i_mem_res_valid ? S_REQ  : S_DROP;
            S_DROP:  state_next = i_mem_res_valid ? S_REQ  : S_DROP;
            default: state_next = S_REQ;
         endcase
      end else begin
         unique case (state)
            S_REQ: begin
               if (handshake) state_next = S_WAIT;
            end
            S_WAIT: begin
               if (i_mem_res_valid) begin
                  state_next       = S_REQ;
                  skip_next        = 2'd0;
                  mem_address_next = mem_address + ADDRESS_WIDTH'(4);
               end
            end
            S_DROP: begin
               if (i_mem_res_valid) state_next = S_REQ;
            end
            default: state_next = S_REQ;
         endcase
         rd_ptr_next    = rd_ptr + PTR_W'(consume_n);
         wr_ptr_next    = push ? wr_ptr + PTR_W'(push_bytes) : wr_ptr;
         occupancy_next = occupancy + 5'(push ? push_bytes : 3'd0) - 5'(consume_n);
         window_pc_next = window_pc + ADDRESS_WIDTH'(consume_n);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_REQ;
         mem_address <= {RESET_PC[ADDRESS_WIDTH-1:2], 2'b00};
         skip        <= RESET_PC[1:0];
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         occupancy   <= '0;
         window_pc   <= RESET_PC;
      end else begin
         state       <= state_next;
         mem_address <= mem_address_next;
         skip        <= skip_next;
         rd_ptr      <= rd_ptr_next;
         wr_ptr      <= wr_ptr_next;
         occupancy   <= occupancy_next;
         window_pc   <= window_pc_next;
      end
   end

   // NOTE: queue storage has no reset; occupancy alone decides which bytes are meaningful.
   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (push_en[k]) queue[push_idx[k]] <= i_mem_data[8*k +: 8];
      end
   end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: a behavioural word memory answers reads, and each
// scenario compares outputs against hand-computed values.
module tb_fetch_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        i_enable = 1'b0;
   logic        i_redirect = 1'b0;
   logic [31:0] i_redirect_pc = '0;
   logic [31:0] o_mem_address;
   logic        o_mem_cmd;
   logic        o_mem_valid;
   logic        i_mem_ready = 1'b1;
   logic [31:0] i_mem_data = '0;
   logic        i_mem_res_valid = 1'b0;
   logic        o_mem_res_ready;
   logic [31:0] o_window;
   logic [2:0]  o_window_count;
   logic        o_window_valid;
   logic [31:0] o_window_pc;
   logic        i_consume = 1'b0;
   logic [2:0]  i_consume_bytes = '0;
   logic [4:0]  o_occupancy;

   int          total = 0;
   int          bad = 0;
   logic [31:0] acc_addr[$];
   logic        pend = 1'b0;
   logic [31:0] pend_addr = '0;
   int          wait_cnt = 0;
   int          resp_lat = 0;

   fetch_controller dut (
      .clk             (clk),
      .reset           (reset),
      .i_enable        (i_enable),
      .i_redirect      (i_redirect),
      .i_redirect_pc   (i_redirect_pc),
      .o_mem_address   (o_mem_address),
      .o_mem_cmd       (o_mem_cmd),
      .o_mem_valid     (o_mem_valid),
      .i_mem_ready     (i_mem_ready),
      .i_mem_data      (i_mem_data),
      .i_mem_res_valid (i_mem_res_valid),
      .o_mem_res_ready (o_mem_res_ready),
      .o_window        (o_window),
      .o_window_count  (o_window_count),
      .o_window_valid  (o_window_valid),
      .o_window_pc     (o_window_pc),
      .i_consume       (i_consume),
      .i_consume_bytes (i_consume_bytes),
      .o_occupancy     (o_occupancy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Byte k of the word at address a holds the low byte of a+k.
   function automatic logic [31:0] word_at(input logic [31:0] a);
      logic [7:0] b;
      b = a[7:0];
      return {b + 8'd3, b + 8'd2, b + 8'd1, b};
   endfunction

   function automatic logic [31:0] acc_at(input int i);
      if (i < acc_addr.size()) return acc_addr[i];
      return 32'hDEAD_BEEF;
   endfunction

   // One clock: handshake sampled at the falling edge, memory model updated 1 ns after the rise.
   task automatic tick();
      logic        hs;
      logic [31:0] a;
      @(negedge clk);
      hs = o_mem_valid && i_mem_ready;
      a  = o_mem_address;
      @(posedge clk);
      #1;
      if (i_mem_res_valid) i_mem_res_valid = 1'b0;
      if (hs) begin
         acc_addr.push_back(a);
         pend      = 1'b1;
         pend_addr = a;
         wait_cnt  = resp_lat;
      end
      if (pend) begin
         if (wait_cnt == 0) begin
            i_mem_res_valid = 1'b1;
            i_mem_data      = word_at(pend_addr);
            pend            = 1'b0;
         end else begin
            wait_cnt--;
         end
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic tick_until_occ(input logic [4:0] target, input string tag);
      int n = 0;
      while (o_occupancy != target && n < 60) begin
         tick();
         n++;
      end
      check(tag, 32'(o_occupancy), 32'(target));
   endtask

   task automatic tick_until_log(input int size, input string tag);
      int n = 0;
      while (acc_addr.size() < size && n < 60) begin
         tick();
         n++;
      end
      check(tag, 32'(acc_addr.size()), 32'(size));
   endtask

   task automatic consume(input logic [2:0] n);
      i_consume       = 1'b1;
      i_consume_bytes = n;
      tick();
      i_consume       = 1'b0;
      i_consume_bytes = '0;
   endtask

   task automatic redirect(input logic [31:0] pc);
      i_redirect    = 1'b1;
      i_redirect_pc = pc;
      tick();
      i_redirect    = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"},  32'(o_mem_valid), 32'd0);
      check({tag, "_addr"},   o_mem_address, 32'h0);
      check({tag, "_window"}, o_window, 32'h0);
      check({tag, "_count"},  32'(o_window_count), 32'd0);
      check({tag, "_wvalid"}, 32'(o_window_valid), 32'd0);
      check({tag, "_pc"},     o_window_pc, 32'h0);
      check({tag, "_occ"},    32'(o_occupancy), 32'd0);
   endtask

   initial begin
      int base;

      // Reset with enable high: the request must stay hidden.
      #1 reset = 1'b1;
      i_enable = 1'b1;
      #1;
      check_reset_outputs("rst");
      check("rst_res_ready", 32'(o_mem_res_ready), 32'd1);
      ticks(2);
      reset = 1'b0;

      // Test 1: two words fetched from 0, window at PC 0, then consume 2.
      tick_until_occ(5'd8, "t1_fill");
      i_enable = 1'b0;
      check("t1_window", o_window, 32'h0302_0100);
      check("t1_count",  32'(o_window_count), 32'd4);
      check("t1_wvalid", 32'(o_window_valid), 32'd1);
      check("t1_pc",     o_window_pc, 32'h0);
      consume(3'd2);
      check("t1_window2", o_window, 32'h0504_0302);
      check("t1_pc2",     o_window_pc, 32'h2);
      check("t1_occ2",    32'(o_occupancy), 32'd6);
      consume(3'd5);
      check("t1_ign_pc",  o_window_pc, 32'h2);
      check("t1_ign_occ", 32'(o_occupancy), 32'd6);
      consume(3'd4);
      check("t1_c4_occ",    32'(o_occupancy), 32'd2);
      check("t1_c4_count",  32'(o_window_count), 32'd2);
      check("t1_c4_window", o_window, 32'h0000_0706);
      consume(3'd4);
      check("t1_clamp_pc",  o_window_pc, 32'h8);
      check("t1_clamp_occ", 32'(o_occupancy), 32'd0);

      // Test 2: fill to 16 bytes without consuming, then free one word.
      redirect(32'h0);
      check("t2_redir_addr", o_mem_address, 32'h0);
      acc_addr.delete();
      i_enable = 1'b1;
      ticks(20);
      check("t2_reads", 32'(acc_addr.size()), 32'd4);
      for (int i = 0; i < 4; i++) check("t2_addr", acc_at(i), 32'(4 * i));
      check("t2_occ",   32'(o_occupancy), 32'd16);
      check("t2_valid", 32'(o_mem_valid), 32'd0);
      consume(3'd4);
      ticks(10);
      check("t2_reads2", 32'(acc_addr.size()), 32'd5);
      check("t2_addr10", acc_at(4), 32'h10);
      check("t2_occ2",   32'(o_occupancy), 32'd16);
      check("t2_pc",     o_window_pc, 32'h4);
      check("t2_window", o_window, 32'h0706_0504);
      i_enable = 1'b0;

      // Test 3: redirect to 0x6 while a read is outstanding.
      redirect(32'h100);
      resp_lat = 3;
      i_enable = 1'b1;
      base = acc_addr.size();
      tick_until_log(base + 1, "t3_accept");
      redirect(32'h6);
      resp_lat = 0;
      check("t3_drop_valid", 32'(o_mem_valid), 32'd0);
      check("t3_drop_pc",    o_window_pc, 32'h6);
      check("t3_drop_occ",   32'(o_occupancy), 32'd0);
      tick_until_occ(5'd2, "t3_push2");
      check("t3_addr4",  acc_at(base + 1), 32'h4);
      check("t3_count",  32'(o_window_count), 32'd2);
      check("t3_window", o_window, 32'h0000_0706);
      check("t3_pc",     o_window_pc, 32'h6);
      tick_until_log(base + 3, "t3_next");
      check("t3_addr8", acc_at(base + 2), 32'h8);
      i_enable = 1'b0;
      ticks(5);

      // Test 4: memory not ready for 5 cycles.
      redirect(32'h40);
      i_mem_ready = 1'b0;
      i_enable = 1'b1;
      base = acc_addr.size();
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t4_valid", 32'(o_mem_valid), 32'd1);
         check("t4_addr",  o_mem_address, 32'h40);
      end
      check("t4_none", 32'(acc_addr.size()), 32'(base));
      i_mem_ready = 1'b1;
      tick();
      i_enable = 1'b0;
      check("t4_one",      32'(acc_addr.size()), 32'(base + 1));
      check("t4_acc_addr", acc_at(base), 32'h40);
      check("t4_valid_lo", 32'(o_mem_valid), 32'd0);
      ticks(3);

      // Test 5: push 4 and consume 4 in the same cycle at occupancy 4.
      redirect(32'h80);
      i_enable = 1'b1;
      tick_until_occ(5'd4, "t5_fill");
      check("t5_window0", o_window, 32'h8382_8180);
      tick();
      i_enable = 1'b0;
      check("t5_wait_valid", 32'(o_mem_valid), 32'd0);
      consume(3'd4);
      check("t5_occ",    32'(o_occupancy), 32'd4);
      check("t5_pc",     o_window_pc, 32'h84);
      check("t5_window", o_window, 32'h8786_8584);

      // Test 6: reset between edges while a read is outstanding.
      redirect(32'h200);
      resp_lat = 3;
      i_enable = 1'b1;
      base = acc_addr.size();
      tick_until_log(base + 1, "t6_accept");
      #2 reset = 1'b1;
      #1;
      check_reset_outputs("t6_rst");
      pend = 1'b0;
      i_mem_res_valid = 1'b0;
      i_mem_data = '0;
      ticks(2);
      reset = 1'b0;
      resp_lat = 0;
      base = acc_addr.size();
      tick_until_log(base + 1, "t6_restart");
      check("t6_addr0", acc_at(base), 32'h0);
      tick_until_occ(5'd4, "t6_fill");
      check("t6_window", o_window, 32'h0302_0100);
      check("t6_pc",     o_window_pc, 32'h0);
      i_enable = 1'b0;
      ticks(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
